// File: rtl/aes_pkg.sv
// Shared AES constants, the sequencer state encoding and group-count helpers
// for the folded InvSubBytes datapath.
package aes_pkg;

    localparam int AES_STATE_W   = 128;
    localparam int AES_NUM_BYTES = 16;
    localparam int AES_BYTE_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    function automatic bit legal_num_sbox(input int num_sbox);
        return (num_sbox == 1) || (num_sbox == 2) || (num_sbox == 4) ||
               (num_sbox == 8) || (num_sbox == 16);
    endfunction

    // Number of RUN cycles needed to cover all 16 bytes with num_sbox lookups.
    function automatic int num_groups(input int num_sbox);
        return AES_NUM_BYTES / num_sbox;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Valid/ready bundle for the InvSubBytes sequencer: input state, result and busy.
interface inv_sub_bytes_seq_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] in_state;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] out_state;
    logic                   busy;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );

endinterface

// File: rtl/inv_sub_bytes_seq_inverse_sbox.sv
// Combinational AES inverse S-box lookup (one byte).
module inverse_sbox (
    input  logic [7:0] value,
    output logic [7:0] result
);

    // Row r holds invS(16*r .. 16*r+15), lowest index first.
    localparam logic [0:255][7:0] TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign result = TABLE[value];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Folded InvSubBytes: NUM_SBOX inverse S-boxes rewrite the captured state in place,
// one group of NUM_SBOX bytes per cycle, with valid/ready on both sides.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int NUM_SBOX = 4,
    parameter int STATE_W  = 128
) (
    input logic             clk,
    input logic             rst_n,
    inv_sub_bytes_seq_if.slave bus
);

    localparam int NUM_GROUPS = num_groups(NUM_SBOX);
    localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_GROUPS - 1);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_RUN  = 2'(RUN);
    localparam logic [1:0] S_DONE = 2'(DONE);

    if (!legal_num_sbox(NUM_SBOX)) begin : g_bad_num_sbox
        $error("inv_sub_bytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end
    if (STATE_W != AES_STATE_W) begin : g_bad_state_w
        $error("inv_sub_bytes_seq: STATE_W is fixed at 128");
    end

    logic [1:0]                                 state_reg, state_next;
    logic [CNT_W-1:0]                           cnt_reg, cnt_next;
    logic [AES_NUM_BYTES-1:0][AES_BYTE_W-1:0]   buf_reg, buf_next;

    logic [3:0]            byte_idx [NUM_SBOX];
    logic [AES_BYTE_W-1:0] sbox_in  [NUM_SBOX];
    logic [AES_BYTE_W-1:0] sbox_out [NUM_SBOX];

    // The S-box bank only ever sees buffer bytes, never in_state directly.
    for (genvar gi = 0; gi < NUM_SBOX; gi++) begin : g_sbox
        assign byte_idx[gi] = 4'(int'(cnt_reg) * NUM_SBOX + gi);
        assign sbox_in[gi]  = buf_reg[byte_idx[gi]];

        inverse_sbox u_inverse_sbox (
            .value  (sbox_in[gi]),
            .result (sbox_out[gi])
        );
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        buf_next   = buf_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.in_valid) begin
                    buf_next   = bus.in_state;
                    cnt_next   = '0;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                for (int k = 0; k < NUM_SBOX; k++) begin
                    buf_next[byte_idx[k]] = sbox_out[k];
                end
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            buf_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            buf_reg   <= buf_next;
        end
    end

    assign bus.in_ready  = (state_reg == S_IDLE);
    assign bus.out_valid = (state_reg == S_DONE);
    assign bus.busy      = (state_reg != S_IDLE);
    assign bus.out_state = (state_reg == S_DONE) ? buf_reg : '0;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Randomised bench for inv_sub_bytes_seq: results are checked against an inverse
// S-box derived from GF(2^8) arithmetic, plus latency, backpressure and reset cases.
module tb_inv_sub_bytes_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] inv_tab [256];

    // Main instance, NUM_SBOX = 4.
    inv_sub_bytes_seq_if m_bus ();
    inv_sub_bytes_seq #(.NUM_SBOX(4), .STATE_W(128)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_bus.slave)
    );

    // Sweep instances with NUM_SBOX = 1, 2, 8, 16 sharing one stimulus.
    logic         sw_valid;
    logic [127:0] sw_state;
    logic         sw_ready;
    logic         sw_ov   [4];
    logic         sw_busy [4];
    logic         sw_ir   [4];
    logic [127:0] sw_os   [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int N = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;
        inv_sub_bytes_seq_if sw_bus ();
        assign sw_bus.in_valid  = sw_valid;
        assign sw_bus.in_state  = sw_state;
        assign sw_bus.out_ready = sw_ready;
        assign sw_ov[gi]   = sw_bus.out_valid;
        assign sw_os[gi]   = sw_bus.out_state;
        assign sw_busy[gi] = sw_bus.busy;
        assign sw_ir[gi]   = sw_bus.in_ready;
        inv_sub_bytes_seq #(.NUM_SBOX(N), .STATE_W(128)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sw_bus.slave)
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    task automatic build_model();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b;
            logic [7:0] y;
            b = inv_affine(8'(x));
            y = 8'h00;
            if (b != 8'h00) begin
                for (int c = 1; c < 256; c++) begin
                    if (gf_mul(b, 8'(c)) == 8'h01) y = 8'(c);
                end
            end
            inv_tab[x] = y;
        end
    endtask

    function automatic logic [127:0] model_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- drive helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the main DUT idle; returns once out_valid is seen.
    task automatic do_op(input logic [127:0] st, output int lat, output logic [127:0] res);
        m_bus.in_state = st;
        m_bus.in_valid = 1'b1;
        tick();
        m_bus.in_valid = 1'b0;
        lat = 0;
        res = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (m_bus.out_valid) begin
                lat = k;
                res = m_bus.out_state;
                break;
            end
        end
    endtask

    logic [127:0] byte_i_pat;
    logic [127:0] byte_i_exp;
    logic [127:0] all52;

    initial begin
        int           lat;
        logic [127:0] res;
        logic [127:0] st;
        logic [127:0] held;

        byte_i_pat = 128'h0f0e0d0c0b0a09080706050403020100;
        byte_i_exp = 128'hfbd7f3819ea340bf38a53630d56a0952;
        all52      = {16{8'h52}};

        build_model();
        check("model_byte_i", model_state(byte_i_pat), byte_i_exp);

        rst_n           = 1'b0;
        m_bus.in_valid  = 1'b0;
        m_bus.in_state  = '0;
        m_bus.out_ready = 1'b1;
        sw_valid        = 1'b0;
        sw_state        = '0;
        sw_ready        = 1'b1;
        repeat (3) tick();
        check("rst_in_ready",  128'(m_bus.in_ready),  128'd1);
        check("rst_out_valid", 128'(m_bus.out_valid), 128'd0);
        check("rst_busy",      128'(m_bus.busy),      128'd0);
        check("rst_out_state", m_bus.out_state,       128'd0);
        rst_n = 1'b1;
        tick();

        // All-zero state.
        do_op(128'd0, lat, res);
        check("zero_result",  res, all52);
        check("zero_latency", 128'(lat), 128'd4);
        tick();
        check("zero_back_idle", 128'(m_bus.in_ready), 128'd1);

        // Byte i = i.
        do_op(byte_i_pat, lat, res);
        check("byte_i_result", res, byte_i_exp);
        tick();

        // Boundary bytes 63 and ff, alternating.
        st = {8{8'hff, 8'h63}};
        do_op(st, lat, res);
        check("bound_63", 128'(res[7:0]),  128'h00);
        check("bound_ff", 128'(res[15:8]), 128'h7d);
        check("bound_all", res, model_state(st));
        tick();

        // Random states.
        for (int n = 0; n < 20; n++) begin
            st = rand_state();
            do_op(st, lat, res);
            check($sformatf("rand%0d", n), res, model_state(st));
            check($sformatf("rand%0d_lat", n), 128'(lat), 128'd4);
            tick();
        end

        // Backpressure in DONE, with an in_valid pulse that must be ignored.
        m_bus.out_ready = 1'b0;
        st = rand_state();
        do_op(st, lat, res);
        held = model_state(st);
        check("bp_first", res, held);
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin
                m_bus.in_state = 128'd0;
                m_bus.in_valid = 1'b1;
            end
            tick();
            m_bus.in_valid = 1'b0;
            check($sformatf("bp%0d_valid", c), 128'(m_bus.out_valid), 128'd1);
            check($sformatf("bp%0d_state", c), m_bus.out_state, held);
            check($sformatf("bp%0d_in_ready", c), 128'(m_bus.in_ready), 128'd0);
        end
        m_bus.out_ready = 1'b1;
        tick();
        check("bp_release_valid", 128'(m_bus.out_valid), 128'd0);
        check("bp_release_ready", 128'(m_bus.in_ready),  128'd1);

        // Reset mid-RUN after two groups.
        m_bus.in_state = rand_state();
        m_bus.in_valid = 1'b1;
        tick();
        m_bus.in_valid = 1'b0;
        tick();
        tick();
        check("mid_busy", 128'(m_bus.busy), 128'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 128'(m_bus.out_valid), 128'd0);
        check("mid_rst_ready", 128'(m_bus.in_ready),  128'd1);
        check("mid_rst_busy",  128'(m_bus.busy),      128'd0);
        check("mid_rst_state", m_bus.out_state,       128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_op(128'd0, lat, res);
        check("after_rst_result", res, all52);
        tick();

        // Back-to-back with in_valid held and three queued states.
        begin
            logic [127:0] q [3];
            int           acc_cyc [3];
            int           nacc;
            int           nres;
            int           cyc;
            bit           acc;
            for (int i = 0; i < 3; i++) q[i] = rand_state();
            nacc = 0;
            nres = 0;
            cyc  = 0;
            m_bus.in_state = q[0];
            m_bus.in_valid = 1'b1;
            while (nres < 3 && cyc < 200) begin
                @(negedge clk);
                acc = m_bus.in_valid && m_bus.in_ready;
                if (m_bus.out_valid && nres < 3) begin
                    check($sformatf("b2b%0d_result", nres), m_bus.out_state, model_state(q[nres]));
                    nres++;
                end
                tick();
                cyc++;
                if (acc && nacc < 3) begin
                    acc_cyc[nacc] = cyc;
                    nacc++;
                    if (nacc < 3) m_bus.in_state = q[nacc];
                    else          m_bus.in_valid = 1'b0;
                end
            end
            m_bus.in_valid = 1'b0;
            check("b2b_results_seen", 128'(nres), 128'd3);
            check("b2b_accepts_seen", 128'(nacc), 128'd3);
            if (nacc == 3) begin
                check("b2b_gap01", 128'(acc_cyc[1] - acc_cyc[0]), 128'd6);
                check("b2b_gap12", 128'(acc_cyc[2] - acc_cyc[1]), 128'd6);
            end
        end
        repeat (3) tick();

        // NUM_SBOX sweep: 1, 2, 8, 16.
        begin
            int           sw_lat [4];
            logic [127:0] sw_res [4];
            int           exp_lat [4];
            exp_lat = '{16, 8, 2, 1};
            for (int j = 0; j < 4; j++) begin
                sw_lat[j] = 0;
                sw_res[j] = '0;
                check($sformatf("sw%0d_idle", j), 128'(sw_ir[j]), 128'd1);
            end
            sw_state = byte_i_pat;
            sw_valid = 1'b1;
            tick();
            sw_valid = 1'b0;
            for (int j = 0; j < 4; j++)
                check($sformatf("sw%0d_busy", j), 128'(sw_busy[j]), 128'd1);
            for (int k = 1; k <= 24; k++) begin
                for (int j = 0; j < 4; j++) begin
                    if (sw_ov[j] && sw_lat[j] == 0) begin
                        sw_lat[j] = k - 1;
                        sw_res[j] = sw_os[j];
                    end
                end
                tick();
            end
            for (int j = 0; j < 4; j++) begin
                check($sformatf("sw%0d_result", j), sw_res[j], byte_i_exp);
                check($sformatf("sw%0d_latency", j), 128'(sw_lat[j]), 128'(exp_lat[j]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
